// File: rtl/mod_updown_counter.sv
// mod_updown_counter: parametrised up/down modulo counter with
// wrap/saturate boundaries, terminal-count pulse and PWM compare.
module mod_updown_counter #(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned MAX_VAL   = 255,
   parameter bit          SATURATE  = 1'b0,
   parameter int unsigned RESET_VAL = 0
) (
   input  logic             clk,
   input  logic             arst,
   input  logic             en,
   input  logic             up_dn,
   input  logic             clr,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic [WIDTH-1:0] cmp_val,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             pwm_out
);

   localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX_VAL);
   localparam logic [WIDTH-1:0] RSTV = WIDTH'(RESET_VAL);
   localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
   localparam logic [WIDTH-1:0] BND  = SATURATE ? MAXV : '0;
   localparam logic [WIDTH-1:0] BNDD = SATURATE ? '0 : MAXV;

   logic [WIDTH-1:0] cnt_nxt;
   logic             tc_nxt;
   logic             at_max;
   logic             at_zero;

   assign at_max  = (count == MAXV);
   assign at_zero = (count == '0);

   // Next count: clear beats load beats step; boundaries are
   // caught before the +1/-1 so natural rollover is never used.
   always_comb begin
      cnt_nxt = count;
      tc_nxt  = 1'b0;
      if (clr) begin
         cnt_nxt = '0;
      end else if (load) begin
         cnt_nxt = (load_val > MAXV) ? MAXV : load_val;
      end else if (en) begin
         if (up_dn) begin
            if (at_max) begin
               cnt_nxt = BND;
               tc_nxt  = 1'b1;
            end else begin
               cnt_nxt = count + ONE;
            end
         end else begin
            if (at_zero) begin
               cnt_nxt = BNDD;
               tc_nxt  = 1'b1;
            end else begin
               cnt_nxt = count - ONE;
            end
         end
      end
   end

   // Register count with tc and pwm aligned to the new value.
   always_ff @(posedge clk or negedge arst) begin
      if (!arst) begin
         count   <= RSTV;
         tc      <= 1'b0;
         pwm_out <= 1'b0;
      end else begin
         count   <= cnt_nxt;
         tc      <= tc_nxt;
         pwm_out <= (cnt_nxt < cmp_val);
      end
   end

endmodule
